reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Round-robin controller that shares a bank of 32-bit asynchronously-reset configuration registers between several requesters. Each requester issues single read or byte-strobed write operations over a valid/ready handshake and gets a response over a second handshake. The block owns the register storage and drives a flat copy of every register to downstream logic as static configuration.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- NUM_REGS, 8: number of 32-bit registers (2..16, need not be a power of two).
- RESET_VALUE, 32'h0: reset value of every register.
- ADDR_W, derived $clog2(NUM_REGS) (min 1): register index width.
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  register index, requester i at slice i.
- req_wdata  in  NUM_REQ*32  write data.
- req_wstrb  in  NUM_REQ*4  byte enables (bit b covers bits 8b+7:8b).
- rsp_valid  out  NUM_REQ  response valid, only the owning requester's bit.
- rsp_ready  in  NUM_REQ  response accept.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  operation rejected.
- regs_q  out  NUM_REGS*32  current register contents, register k at slice k.

## Operation
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- IDLE: winner = first requester with req_valid set, scanning from rr_ptr upward, wrapping at NUM_REQ. req_ready[winner] high combinationally; all others low. No valid -> no ready, stay IDLE.
- Handshake (valid & ready): latch index, write, addr, wdata, wstrb; rr_ptr <= (winner+1) mod NUM_REQ; -> EXEC.
- EXEC: addr >= NUM_REGS -> err=1, no write, rdata=0. Write: reg[addr] <= (reg & ~mask) | (wdata & mask), mask = byte-expanded wstrb; wstrb=0 is a legal no-op with err=0. Read: rdata <= reg[addr]. -> RESP.
- RESP: rsp_valid[idx]=1 with stable rsp_rdata/rsp_err until rsp_ready[idx]; then -> IDLE. rsp_ready of other requesters ignored.
- req_ready is low in EXEC and RESP; requester inputs are ignored outside IDLE.
- A requester holding req_valid continuously is served once per rotation; no starvation.
- Reset (any time, including mid-EXEC/RESP): state IDLE, rr_ptr 0, all registers RESET_VALUE, rsp_valid 0, rsp_rdata 0, rsp_err 0; the in-flight operation is dropped with no response.

## Timing
- Accept at edge N; register update visible on regs_q after edge N+1; rsp_valid high from edge N+1.
- With rsp_ready tied high, rsp handshake completes at edge N+2, and the next req_ready is asserted in the cycle after that: one operation per 3 cycles.
- req_ready depends combinationally on req_valid; all other outputs are registered.
- A read issued right after a write to the same register returns the written value.

## Configuration
- REG_BANK_ARBITER_LOCK_EN defined: register NUM_REGS-1 is a lock mask. Bit k set means writes to register k return err=1 and do not modify it. A write to the lock register ORs the masked wdata in (sticky). Lock bits clear only on reset. Reads are never locked.
- Not defined: all registers are plain storage; err only for out-of-range addresses.

## Structure
- Package reg_bank_pkg: state enum (IDLE/EXEC/RESP), strobe-to-bitmask function, ADDR_W helper function.
- Sub-module rr_arbiter: combinational round-robin picker (valid vector and pointer in, one-hot grant out); the top level holds rr_ptr and applies the pointer update.

## Test plan
- Reset, then read every register -> rdata = RESET_VALUE, err=0; regs_q all RESET_VALUE.
- Req0 writes reg2 = 32'hDEADBEEF, wstrb 4'b0101, then reads reg2 -> 32'h00AD00EF (RESET_VALUE 0); regs_q slice 2 matches one edge after accept.
- All 4 requesters valid continuously -> grants 0,1,2,3,0 in that order; each rsp_valid appears only on its owner.
- Read addr NUM_REGS (8) -> err=1, rdata=0, no register changes; rsp held 5 cycles with rsp_ready low, then accepted.
- rst_n pulsed low during EXEC of a write to reg1 = 32'h1234 -> no rsp_valid, reg1 = RESET_VALUE, next grant goes to requester 0.
- With LOCK_EN: write reg7 = 32'h2, then write reg1 = 32'h55 -> err=1, reg1 unchanged; write reg7 = 0 -> bit 1 stays set.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the reg_bank_arbiter slice: FSM state encoding,
// byte-strobe expansion and index-width calculation.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Expand a 4-bit byte-enable into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side request/response bus of reg_bank_arbiter; master = requesters,
// slave = the arbiter.
interface reg_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*32-1:0]     req_wdata;
  logic [NUM_REQ*4-1:0]      req_wstrb;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reg_bank_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping at NUM_REQ; one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  always_comb begin
    logic              found;
    logic [PTR_W-1:0]  cand;
    int unsigned       pos;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    pos       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos  = (32'(ptr) + i) % NUM_REQ;
      cand = PTR_W'(pos);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin shared configuration register bank with per-requester handshakes.
// Optional REG_BANK_ARBITER_LOCK_EN turns the last register into a sticky write-lock mask.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned ADDR_W      = idx_width(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reg_bank_arbiter_if.slave        bus,
  output logic [NUM_REGS*32-1:0]   regs_q
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   idx_q;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;
  logic [31:0]        reg_mem_q [NUM_REGS];

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_wstrb;
  logic               in_range;
  logic               locked;
  logic               op_err;
  logic [31:0]        cur_reg;
  logic [31:0]        mask;
  logic [31:0]        wr_value;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .valid     (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = (state_q == StIdle) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot mux of the winning requester's operation fields.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*32 +: 32];
        sel_wstrb = bus.req_wstrb[i*4 +: 4];
      end
    end
  end

  always_comb begin
    in_range = (32'(addr_q) < NUM_REGS);
    cur_reg  = in_range ? reg_mem_q[addr_q] : '0;
    mask     = strb_to_mask(wstrb_q);
    wr_value = (cur_reg & ~mask) | (wdata_q & mask);
    locked   = 1'b0;
`ifdef REG_BANK_ARBITER_LOCK_EN
    locked = write_q && in_range && reg_mem_q[NUM_REGS-1][addr_q];
    // Lock bits are sticky: the lock register only accumulates set bits.
    if (addr_q == ADDR_W'(NUM_REGS - 1)) begin
      wr_value = cur_reg | (wdata_q & mask);
    end
`endif
    op_err = !in_range || locked;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        reg_mem_q[k] <= RESET_VALUE;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            idx_q    <= grant_idx;
            write_q  <= sel_write;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            wstrb_q  <= sel_wstrb;
            rr_ptr_q <= ptr_next;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_valid_q[idx_q] <= 1'b1;
          rsp_err_q          <= op_err;
          rsp_rdata_q        <= (!write_q && !op_err) ? cur_reg : '0;
          if (write_q && !op_err) begin
            reg_mem_q[addr_q] <= wr_value;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready[idx_q]) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_q[k*32 +: 32] = reg_mem_q[k];
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed plus randomized bench for reg_bank_arbiter against a transaction-level model.
// NUM_REGS is 6 so that out-of-range indices are encodable with a 3-bit address.
module tb_reg_bank_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned ADDR_W   = 3;
  localparam logic [31:0] RV       = 32'h0;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_REGS*32-1:0] regs_q;

  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  reg_bank_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RV),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .regs_q (regs_q)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Requester-side operation table and model state.
  logic [NUM_REQ-1:0] vld;
  bit                 op_write [NUM_REQ];
  int                 op_addr  [NUM_REQ];
  logic [31:0]        op_wdata [NUM_REQ];
  logic [3:0]         op_wstrb [NUM_REQ];
  logic [31:0]        m_regs   [NUM_REGS];
  int                 m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    if (s[0]) m = m | 32'h0000_00FF;
    if (s[1]) m = m | 32'h0000_FF00;
    if (s[2]) m = m | 32'h00FF_0000;
    if (s[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (vld[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int ready_index();
    for (int k = 0; k < int'(NUM_REQ); k++) if (bus.req_ready[k]) return k;
    return -1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < int'(NUM_REGS); k++) m_regs[k] = RV;
    m_ptr = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_write[i]             = op_write[i];
      bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(op_addr[i]);
      bus.req_wdata[i*32 +: 32]    = op_wdata[i];
      bus.req_wstrb[i*4 +: 4]      = op_wstrb[i];
    end
    bus.req_valid = vld;
  endtask

  task automatic rand_op(input int i);
    op_write[i] = 1'($urandom_range(0, 1));
    op_addr[i]  = $urandom_range(0, 7);
    op_wdata[i] = $urandom;
    op_wstrb[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < int'(NUM_REGS); k++) check(tag, regs_q[k*32 +: 32], m_regs[k]);
  endtask

  // One full transaction: arbitration, execute, response held `hold` cycles.
  task automatic serve(input int hold, input bit refresh, output int obs_w);
    int cyc;
    int w;
    int a;
    bit exp_err;
    logic [31:0] exp_rd;
    logic [31:0] m;
    cyc = 0;
    #1;
    while (bus.req_ready == '0 && cyc < 16) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    w     = model_winner();
    obs_w = ready_index();
    check("req_ready", 32'(bus.req_ready), 32'(onehot(w)));
    if (w < 0) return;
    a       = op_addr[w];
    exp_err = (a >= int'(NUM_REGS));
`ifdef REG_BANK_ARBITER_LOCK_EN
    if (!exp_err && op_write[w] && m_regs[NUM_REGS-1][a]) exp_err = 1'b1;
`endif
    exp_rd = (!op_write[w] && !exp_err) ? m_regs[a] : 32'h0;
    if (op_write[w] && !exp_err) begin
      m = byte_mask(op_wstrb[w]);
`ifdef REG_BANK_ARBITER_LOCK_EN
      if (a == int'(NUM_REGS) - 1) m_regs[a] = m_regs[a] | (op_wdata[w] & m);
      else m_regs[a] = (m_regs[a] & ~m) | (op_wdata[w] & m);
`else
      m_regs[a] = (m_regs[a] & ~m) | (op_wdata[w] & m);
`endif
    end
    m_ptr = (w + 1) % NUM_REQ;
    @(negedge clk);
    check("ready_busy", 32'(bus.req_ready), 32'h0);
    check("rsp_early", 32'(bus.rsp_valid), 32'h0);
    if (refresh) begin
      rand_op(w);
      vld[w] = 1'($urandom_range(0, 1));
      drive();
    end
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(onehot(w)));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check_regs("regs_q");
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = ~onehot(w);
      @(negedge clk);
      check("rsp_hold_valid", 32'(bus.rsp_valid), 32'(onehot(w)));
      check("rsp_hold_rdata", bus.rsp_rdata, exp_rd);
      check("rsp_hold_err", 32'(bus.rsp_err), 32'(exp_err));
    end
    bus.rsp_ready = onehot(w);
    @(negedge clk);
    bus.rsp_ready = '0;
    check("rsp_done", 32'(bus.rsp_valid), 32'h0);
    if (vld != '0) check("ready_after_rsp", 32'(bus.req_ready != '0), 32'h1);
  endtask

  task automatic single(input int r, input bit wr, input int a, input logic [31:0] d,
                        input logic [3:0] s, input int hold);
    int obs;
    vld         = '0;
    vld[r]      = 1'b1;
    op_write[r] = wr;
    op_addr[r]  = a;
    op_wdata[r] = d;
    op_wstrb[r] = s;
    drive();
    serve(hold, 1'b0, obs);
    check("single_grant", 32'(obs), 32'(r));
    vld = '0;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = '0;
    drive();
    bus.rsp_ready = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int obs;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      op_write[i] = 1'b0;
      op_addr[i]  = 0;
      op_wdata[i] = '0;
      op_wstrb[i] = '0;
    end
    do_reset();

    #1;
    check("idle_no_ready", 32'(bus.req_ready), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rdata", bus.rsp_rdata, 32'h0);
    check("reset_err", 32'(bus.rsp_err), 32'h0);
    check_regs("reset_regs");

    for (int a = 0; a < int'(NUM_REGS); a++) single(0, 1'b0, a, 32'h0, 4'h0, 0);

    single(0, 1'b1, 2, 32'hDEAD_BEEF, 4'b0101, 0);
    check("strobe_write", regs_q[2*32 +: 32], 32'h00AD_00EF);
    single(0, 1'b0, 2, 32'h0, 4'h0, 0);
    single(1, 1'b1, 3, 32'hFFFF_FFFF, 4'h0, 0);
    single(2, 1'b0, NUM_REGS, 32'h0, 4'h0, 5);
    single(3, 1'b1, 7, 32'hCAFE_F00D, 4'hF, 1);

    // Reset while a write to reg1 from requester 1 is executing.
    vld         = 4'b0010;
    op_write[1] = 1'b1;
    op_addr[1]  = 1;
    op_wdata[1] = 32'h0000_1234;
    op_wstrb[1] = 4'hF;
    drive();
    #1;
    check("rst_test_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    vld = '0;
    drive();
    rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_async_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_async_reg1", regs_q[1*32 +: 32], RV);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    check_regs("rst_regs");

    // All requesters valid continuously: strict rotation starting at 0.
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      op_write[i] = 1'b0;
      op_addr[i]  = i;
    end
    vld = 4'hF;
    drive();
    for (int i = 0; i < 5; i++) begin
      serve(0, 1'b0, obs);
      check("grant_seq", 32'(obs), 32'(i % NUM_REQ));
    end
    vld = '0;
    drive();

    for (int i = 0; i < int'(NUM_REQ); i++) rand_op(i);
    for (int n = 0; n < 40; n++) begin
      if (vld == '0) begin
        vld = 4'($urandom_range(1, 15));
        drive();
      end
      serve($urandom_range(0, 2), 1'b1, obs);
    end
    vld = '0;
    drive();

`ifdef REG_BANK_ARBITER_LOCK_EN
    do_reset();
    single(0, 1'b1, NUM_REGS - 1, 32'h2, 4'hF, 0);
    single(1, 1'b1, 1, 32'h55, 4'hF, 0);
    check("lock_reg1", regs_q[1*32 +: 32], RV);
    single(2, 1'b1, NUM_REGS - 1, 32'h0, 4'hF, 0);
    check("lock_sticky", regs_q[(NUM_REGS-1)*32 +: 32] & 32'h2, 32'h2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
